// File: rtl/usb20sr_refdes_ram_pkg.sv
// Shared types and helpers for the USB 2.0 reference design dual-port RAM.
// Helpers work on the widest supported word; callers cast to their width.
package usb20sr_refdes_ram_pkg;

    typedef enum logic {CLEAR, RUN} ram_state_e;

    localparam int DEF_DATA_W = 32;
    localparam int BE_W       = DEF_DATA_W / 8;
    localparam int MAX_BE_W   = 64;
    localparam int MAX_DATA_W = 8 * MAX_BE_W;

    typedef logic [MAX_DATA_W-1:0] word_t;
    typedef logic [MAX_BE_W-1:0]   be_t;

    function automatic word_t byte_merge(
        input word_t old_w,
        input word_t new_w,
        input be_t   be
    );
        word_t res;
        res = old_w;
        for (int i = 0; i < MAX_BE_W; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    // s1 owns every lane it enables when both ports hit one word
    function automatic be_t coll_mask(
        input logic match,
        input be_t  s1_be,
        input be_t  s2_be
    );
        return match ? (s2_be & ~s1_be) : s2_be;
    endfunction

endpackage

// File: rtl/usb20sr_refdes_dpram_core.sv
// True-dual-port byte-enable RAM array; read data is captured at the clock
// edge so a read always sees the word as it was before that edge's writes.
module usb20sr_refdes_dpram_core
    import usb20sr_refdes_ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 33750,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_i,
    input  logic                a_we_i,
    input  logic                a_re_i,
    input  logic                a_zero_i,
    input  logic [IDX_W-1:0]    a_addr_i,
    input  logic [DATA_W/8-1:0] a_be_i,
    input  logic [DATA_W-1:0]   a_wd_i,
    output logic [DATA_W-1:0]   a_q_o,
    input  logic                b_we_i,
    input  logic                b_re_i,
    input  logic                b_zero_i,
    input  logic [IDX_W-1:0]    b_addr_i,
    input  logic [DATA_W/8-1:0] b_be_i,
    input  logic [DATA_W-1:0]   b_wd_i,
    output logic [DATA_W-1:0]   b_q_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] a_q_q;
    logic [DATA_W-1:0] b_q_q;
    logic [DATA_W-1:0] a_word_d;
    logic [DATA_W-1:0] b_word_d;
    logic [DATA_W-1:0] ab_word_d;
    logic              same_addr;

    always_comb begin
        same_addr = (a_addr_i == b_addr_i);
        a_word_d  = DATA_W'(byte_merge(MAX_DATA_W'(mem_q[a_addr_i]),
                                       MAX_DATA_W'(a_wd_i),
                                       MAX_BE_W'(a_be_i)));
        b_word_d  = DATA_W'(byte_merge(MAX_DATA_W'(mem_q[b_addr_i]),
                                       MAX_DATA_W'(b_wd_i),
                                       MAX_BE_W'(b_be_i)));
        ab_word_d = DATA_W'(byte_merge(MAX_DATA_W'(b_word_d),
                                       MAX_DATA_W'(a_wd_i),
                                       MAX_BE_W'(a_be_i)));
    end

    always_ff @(posedge clk) begin
        if (a_we_i && b_we_i && same_addr) begin
            mem_q[a_addr_i] <= ab_word_d;
        end else begin
            if (a_we_i) begin
                mem_q[a_addr_i] <= a_word_d;
            end
            if (b_we_i) begin
                mem_q[b_addr_i] <= b_word_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            a_q_q <= '0;
            b_q_q <= '0;
        end else begin
            if (a_re_i) begin
                a_q_q <= a_zero_i ? '0 : mem_q[a_addr_i];
            end
            if (b_re_i) begin
                b_q_q <= b_zero_i ? '0 : mem_q[b_addr_i];
            end
        end
    end

    assign a_q_o = a_q_q;
    assign b_q_o = b_q_q;

endmodule

// File: rtl/usb20sr_refdes_onchip_ram_dp.sv
// Dual Avalon-MM slave on-chip RAM: clear sequencer, accept logic,
// out-of-range guard and readdatavalid/readdata pipelines.
module usb20sr_refdes_onchip_ram_dp
    import usb20sr_refdes_ram_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 16,
    parameter int DEPTH          = 33750,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                reset_req,
    input  logic [ADDR_W-1:0]   s1_address,
    input  logic                s1_chipselect,
    input  logic                s1_read,
    input  logic                s1_write,
    input  logic [DATA_W/8-1:0] s1_byteenable,
    input  logic [DATA_W-1:0]   s1_writedata,
    output logic [DATA_W-1:0]   s1_readdata,
    output logic                s1_readdatavalid,
    output logic                s1_waitrequest,
    input  logic [ADDR_W-1:0]   s2_address,
    input  logic                s2_chipselect,
    input  logic                s2_read,
    input  logic                s2_write,
    input  logic [DATA_W/8-1:0] s2_byteenable,
    input  logic [DATA_W-1:0]   s2_writedata,
    output logic [DATA_W-1:0]   s2_readdata,
    output logic                s2_readdatavalid,
    output logic                s2_waitrequest,
    output logic                init_done,
    output logic                oor_err
);

    localparam int              NBE   = DATA_W / 8;
    localparam int              IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    ram_state_e        state_q;
    logic [IDX_W-1:0]  clr_cnt_q;
    logic              init_done_q;
    logic              oor_err_q;
    logic              s1_v1_q;
    logic              s2_v1_q;

    logic              stall;
    logic              s1_oor, s2_oor;
    logic              s1_acc, s2_acc;
    logic              s1_wr, s2_wr;
    logic              s1_rd, s2_rd;
    logic              a_we, b_we;
    logic [IDX_W-1:0]  a_addr, b_addr;
    logic [NBE-1:0]    a_be, b_be;
    logic [DATA_W-1:0] a_wd;
    logic [DATA_W-1:0] a_q, b_q;

    assign stall = reset | reset_req | (state_q == CLEAR);

    always_comb begin
        s1_oor = ({1'b0, s1_address} >= LIMIT);
        s2_oor = ({1'b0, s2_address} >= LIMIT);
        s1_acc = s1_chipselect & (s1_read | s1_write) & ~stall;
        s2_acc = s2_chipselect & (s2_read | s2_write) & ~stall;
        s1_wr  = s1_acc & s1_write;
        s2_wr  = s2_acc & s2_write;
        s1_rd  = s1_acc & s1_read & ~s1_write;
        s2_rd  = s2_acc & s2_read & ~s2_write;

        a_we   = s1_wr & ~s1_oor;
        a_addr = s1_address[IDX_W-1:0];
        a_be   = s1_byteenable;
        a_wd   = s1_writedata;
        // The clear sequencer borrows port A; s1 is stalled meanwhile
        if (state_q == CLEAR && !reset) begin
            a_we   = 1'b1;
            a_addr = clr_cnt_q;
            a_be   = '1;
            a_wd   = '0;
        end

        b_we   = s2_wr & ~s2_oor;
        b_addr = s2_address[IDX_W-1:0];
        b_be   = NBE'(coll_mask(a_we && (a_addr == b_addr),
                                MAX_BE_W'(a_be),
                                MAX_BE_W'(s2_byteenable)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            clr_cnt_q   <= '0;
            init_done_q <= 1'b0;
            oor_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                CLEAR: begin
                    if (clr_cnt_q == LAST) begin
                        state_q     <= RUN;
                        init_done_q <= 1'b1;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + IDX_W'(1);
                    end
                end
                RUN: begin
                    init_done_q <= 1'b1;
                end
            endcase
            if ((s1_acc & s1_oor) | (s2_acc & s2_oor)) begin
                oor_err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v1_q <= 1'b0;
            s2_v1_q <= 1'b0;
        end else begin
            s1_v1_q <= s1_rd;
            s2_v1_q <= s2_rd;
        end
    end

    usb20sr_refdes_dpram_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_core (
        .clk      (clk),
        .rst_i    (reset),
        .a_we_i   (a_we),
        .a_re_i   (s1_rd),
        .a_zero_i (s1_oor),
        .a_addr_i (a_addr),
        .a_be_i   (a_be),
        .a_wd_i   (a_wd),
        .a_q_o    (a_q),
        .b_we_i   (b_we),
        .b_re_i   (s2_rd),
        .b_zero_i (s2_oor),
        .b_addr_i (b_addr),
        .b_be_i   (b_be),
        .b_wd_i   (s2_writedata),
        .b_q_o    (b_q)
    );

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic              s1_v2_q, s2_v2_q;
            logic [DATA_W-1:0] s1_rd2_q, s2_rd2_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_v2_q  <= 1'b0;
                    s2_v2_q  <= 1'b0;
                    s1_rd2_q <= '0;
                    s2_rd2_q <= '0;
                end else begin
                    s1_v2_q <= s1_v1_q;
                    s2_v2_q <= s2_v1_q;
                    if (s1_v1_q) begin
                        s1_rd2_q <= a_q;
                    end
                    if (s2_v1_q) begin
                        s2_rd2_q <= b_q;
                    end
                end
            end

            assign s1_readdatavalid = s1_v2_q;
            assign s2_readdatavalid = s2_v2_q;
            assign s1_readdata      = s1_rd2_q;
            assign s2_readdata      = s2_rd2_q;
        end else begin : g_lat1
            assign s1_readdatavalid = s1_v1_q;
            assign s2_readdatavalid = s2_v1_q;
            assign s1_readdata      = a_q;
            assign s2_readdata      = b_q;
        end
    endgenerate

    assign s1_waitrequest = stall;
    assign s2_waitrequest = stall;
    assign init_done      = init_done_q;
    assign oor_err        = oor_err_q;

endmodule

// File: tb/tb_usb20sr_refdes_onchip_ram_dp.sv
// Bench for the dual-port RAM: one latency-1 and one latency-2 instance share
// stimulus and are checked every cycle against a word-array reference model.
module tb_usb20sr_refdes_onchip_ram_dp;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 rreq;
    logic [1:0][AW-1:0]   addr;
    logic [1:0]           cs, rd, wr;
    logic [1:0][3:0]      be;
    logic [1:0][DW-1:0]   wd;

    // stream s = 2*dut + port; dut 0 has latency 1, dut 1 latency 2
    logic [3:0][DW-1:0]   rdata;
    logic [3:0]           rvalid;
    logic [3:0]           wreq;
    logic [1:0]           idone;
    logic [1:0]           oerr;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        usb20sr_refdes_onchip_ram_dp #(
            .DATA_W         (DW),
            .ADDR_W         (AW),
            .DEPTH          (DEPTH),
            .READ_LATENCY   (g + 1),
            .CLEAR_ON_RESET (1)
        ) u_dut (
            .clk              (clk),
            .reset            (rst),
            .reset_req        (rreq),
            .s1_address       (addr[0]),
            .s1_chipselect    (cs[0]),
            .s1_read          (rd[0]),
            .s1_write         (wr[0]),
            .s1_byteenable    (be[0]),
            .s1_writedata     (wd[0]),
            .s1_readdata      (rdata[2*g]),
            .s1_readdatavalid (rvalid[2*g]),
            .s1_waitrequest   (wreq[2*g]),
            .s2_address       (addr[1]),
            .s2_chipselect    (cs[1]),
            .s2_read          (rd[1]),
            .s2_write         (wr[1]),
            .s2_byteenable    (be[1]),
            .s2_writedata     (wd[1]),
            .s2_readdata      (rdata[2*g+1]),
            .s2_readdatavalid (rvalid[2*g+1]),
            .s2_waitrequest   (wreq[2*g+1]),
            .init_done        (idone[g]),
            .oor_err          (oerr[g])
        );
    end

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] exp_rd [int];
    logic [DW-1:0] last_rd [4];
    int            clear_left;
    bit            m_init, m_oor, m_live;
    int            ecount;
    int            n_vec, n_err;
    bit            obs_init, obs_wait;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        logic [DW-1:0] nm [DEPTH];
        logic [DW-1:0] d;
        int            ai;
        if (rst) begin
            m_live = 1'b1;
            exp_rd.delete();
            for (int s = 0; s < 4; s++) last_rd[s] = '0;
            clear_left = DEPTH;
            m_init = 1'b0;
            m_oor  = 1'b0;
            return;
        end
        if (!m_live) return;
        if (clear_left > 0) begin
            clear_left--;
            if (clear_left == 0) begin
                for (int i = 0; i < DEPTH; i++) mem[i] = '0;
                m_init = 1'b1;
            end
            return;
        end
        if (rreq) return;
        nm = mem;
        // s2 applied first so s1 overrides shared lanes
        for (int p = 1; p >= 0; p--) begin
            if (cs[p] && (rd[p] || wr[p])) begin
                ai = int'(addr[p]);
                if (ai >= DEPTH) m_oor = 1'b1;
                if (wr[p]) begin
                    if (ai < DEPTH) begin
                        for (int b = 0; b < 4; b++) begin
                            if (be[p][b]) nm[ai][8*b +: 8] = wd[p][8*b +: 8];
                        end
                    end
                end else begin
                    d = (ai < DEPTH) ? mem[ai] : '0;
                    exp_rd[ecount*4 + p]           = d;
                    exp_rd[(ecount + 1)*4 + 2 + p] = d;
                end
            end
        end
        mem = nm;
    endtask

    task automatic tick();
        bit w, ev;
        int k;
        @(negedge clk);
        if (m_live) begin
            w = rst | rreq | (clear_left > 0);
            for (int s = 0; s < 4; s++) begin
                k  = ecount*4 + s;
                ev = exp_rd.exists(k);
                if (ev) begin
                    last_rd[s] = exp_rd[k];
                    exp_rd.delete(k);
                end
                chk($sformatf("valid st%0d e%0d", s, ecount), 32'(rvalid[s]), 32'(ev));
                chk($sformatf("rdata st%0d e%0d", s, ecount), rdata[s], last_rd[s]);
                chk($sformatf("waitreq st%0d e%0d", s, ecount), 32'(wreq[s]), 32'(w));
            end
            for (int g = 0; g < 2; g++) begin
                chk($sformatf("init_done d%0d e%0d", g, ecount), 32'(idone[g]), 32'(m_init));
                chk($sformatf("oor_err d%0d e%0d", g, ecount), 32'(oerr[g]), 32'(m_oor));
            end
        end
        obs_init = idone[0];
        obs_wait = wreq[0];
        @(posedge clk);
        ecount++;
        model_edge();
        #1;
    endtask

    task automatic idle();
        cs = '0;
        rd = '0;
        wr = '0;
        be = '0;
    endtask

    task automatic op(input int p, input bit r, input bit w, input int a,
                      input logic [3:0] b, input logic [31:0] d);
        cs[p]   = 1'b1;
        rd[p]   = r;
        wr[p]   = w;
        addr[p] = AW'(a);
        be[p]   = b;
        wd[p]   = d;
    endtask

    task automatic drain();
        idle();
        tick();
        tick();
        tick();
    endtask

    task automatic clear_timing(input string tag);
        int n_wait, first;
        n_wait = 0;
        first  = 0;
        for (int i = 1; i <= 40 && first == 0; i++) begin
            tick();
            if (obs_wait) n_wait++;
            if (obs_init) first = i;
        end
        chk({tag, " wait cycles"}, 32'(n_wait), 32'd16);
        chk({tag, " init cycle"}, 32'(first), 32'd17);
    endtask

    initial begin
        n_vec = 0; n_err = 0; ecount = 0;
        m_live = 1'b0; m_init = 1'b0; m_oor = 1'b0; clear_left = 0;
        addr = '0; wd = '0;
        rst = 1'b1; rreq = 1'b0;
        idle();
        repeat (3) tick();
        rst = 1'b0;
        clear_timing("clear");

        for (int i = 0; i < DEPTH; i++) begin
            idle();
            op(0, 1, 0, i, 4'h0, 0);
            op(1, 1, 0, DEPTH - 1 - i, 4'h0, 0);
            tick();
        end
        drain();

        idle(); op(0, 0, 1, 5, 4'hF, 32'hDEADBEEF); tick();
        idle(); op(0, 1, 0, 5, 4'h0, 0); tick();
        drain();
        chk("wr_rd lat1", rdata[0], 32'hDEADBEEF);
        chk("wr_rd lat2", rdata[2], 32'hDEADBEEF);
        idle(); op(0, 0, 1, 5, 4'h1, 32'h11); tick();
        idle(); op(0, 1, 0, 5, 4'h0, 0); tick();
        idle(); op(1, 0, 1, 5, 4'h0, 32'hFFFFFFFF); tick();
        idle(); op(1, 1, 0, 5, 4'h0, 0); tick();
        drain();
        chk("byte lane lat1", rdata[0], 32'hDEADBE11);
        chk("be0 write lat2", rdata[3], 32'hDEADBE11);

        idle();
        op(0, 0, 1, 3, 4'h3, 32'hAAAAAAAA);
        op(1, 0, 1, 3, 4'hE, 32'hBBBBBBBB);
        tick();
        idle(); op(0, 1, 0, 3, 4'h0, 0); tick();
        drain();
        chk("collision lat1", rdata[0], 32'hBBBBAAAA);
        chk("collision lat2", rdata[2], 32'hBBBBAAAA);

        idle(); op(0, 0, 1, 7, 4'hF, 32'h1); tick();
        idle(); op(1, 0, 1, 7, 4'hF, 32'h2); op(0, 1, 0, 7, 4'h0, 0); tick();
        drain();
        chk("rdw old lat1", rdata[0], 32'h1);
        chk("rdw old lat2", rdata[2], 32'h1);
        idle(); op(0, 1, 0, 7, 4'h0, 0); tick();
        drain();
        chk("rdw new lat1", rdata[0], 32'h2);

        idle(); op(0, 0, 1, 4, 4'hF, 32'hCAFEF00D); op(1, 1, 0, 5, 4'h0, 0); tick();
        idle(); op(1, 0, 1, 20, 4'hF, 32'h12345678); tick();
        idle(); op(1, 1, 0, 20, 4'h0, 0); tick();
        drain();
        chk("oor read lat1", rdata[1], 32'h0);
        chk("oor read lat2", rdata[3], 32'h0);
        chk("oor flag", 32'(oerr), 32'h3);
        idle(); op(0, 1, 0, 4, 4'h0, 0); tick();
        drain();
        chk("oor alias untouched", rdata[0], 32'hCAFEF00D);

        for (int i = 0; i < 8; i++) begin
            idle();
            op(0, 1, 0, i, 4'h0, 0);
            op(1, 1, 0, DEPTH - 1 - i, 4'h0, 0);
            rreq = (i >= 2 && i < 5);
            tick();
        end
        rreq = 1'b0;
        drain();

        for (int n = 0; n < 1500; n++) begin
            rreq = ($urandom_range(0, 15) == 0);
            for (int p = 0; p < 2; p++) begin
                cs[p]   = ($urandom_range(0, 3) != 0);
                rd[p]   = 1'($urandom);
                wr[p]   = 1'($urandom);
                addr[p] = AW'(($urandom_range(0, 1) != 0) ?
                              $urandom_range(0, 3) : $urandom_range(0, 19));
                be[p]   = 4'($urandom);
                wd[p]   = $urandom;
            end
            tick();
        end
        rreq = 1'b0;
        drain();

        idle(); op(0, 1, 0, 5, 4'h0, 0); op(1, 1, 0, 3, 4'h0, 0); tick();
        idle(); rst = 1'b1; tick();
        tick();
        rst = 1'b0;
        repeat (8) tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        clear_timing("reclear");
        idle(); op(0, 1, 0, 9, 4'h0, 0); op(1, 0, 1, 9, 4'hF, 32'h5A5A5A5A); tick();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
